seq_extend_alu: RTL and testbench
=================================

Name: seq_extend_alu

Overview:
Multi-cycle, WIDTH-parametrised successor to the combinational extended ALU of the Hack-style CPU core.
- Keeps the 9-bit instruction encoding and the plain zx/nx/zy/ny/f/no ALU path.
- Re-enables multiplication as an iterative shift-add unit.
- Generalises the 1-bit arithmetic shift to a variable shift amount.
- Sits between the decode stage and the register writeback. Uses a valid/ready handshake so the CPU stalls on long operations.

Parameters:
WIDTH, 16, operand and result width in bits (>= 8).
SHAMT_W, 4, width of the shift-amount field taken from instruction[3:0]; fixed at 4 for this encoding.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation
x  input  WIDTH  signed operand x
y  input  WIDTH  signed operand y
instruction  input  9  operation encoding
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out  output  WIDTH  signed result
zr  output  1  result == 0
ng  output  1  result < 0 (signed)

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
  - Reset clears state to IDLE and clears out, zr, ng and out_valid to 0.
  - in_ready = (state == IDLE), so in_ready reads 1 during and after reset.
- Accept: in_valid && in_ready at a rising edge latches x, y and instruction.
  - Inputs are don't-care at all other times.
- Decode of instruction[8:7]:
  - 11: plain ALU on x, y with zx=[5], nx=[4], zy=[3], ny=[2], f=[1], no=[0]. Result registered at the accept edge. out_valid high in the next cycle (latency 1).
  - 10: reserved. Result 0, latency 1.
  - 01: arithmetic shift.
    - [5:4]: 00 y>>>n, 01 x>>>n, 10 y<<<n, 11 x<<<n.
    - n = instruction[3:0]; n = 0 is treated as n = 1.
    - Performed one bit per cycle in a shift register. Right shifts replicate the MSB.
    - Latency n+1 edges from accept to out_valid.
  - 00: multiply. Result = low WIDTH bits of x*y; two's-complement wraparound, no overflow flag.
    - Shift-add, one multiplier bit per cycle for exactly WIDTH iterations. No early termination.
    - Latency WIDTH+1.
- Instruction bit 6 is ignored.
- FSM states:
  - IDLE: accept -> MUL, SHIFT or DONE according to decode.
  - MUL: iteration counter reaches WIDTH-1 -> DONE.
  - SHIFT: remaining count reaches 0 -> DONE.
  - DONE: out_valid=1; out_valid && out_ready -> IDLE.
- Outputs: out, zr and ng are registered together when entering DONE.
  - They are stable while out_valid is high and out_ready is low.
  - After the output handshake they hold their values until the next result is written. out_valid drops in the cycle after the handshake.
- No overlap: in_ready=0 in MUL, SHIFT and DONE. in_valid pulses during those states are ignored and not queued.
- Minimum issue interval: two cycles (accept, then DONE with out_ready high).
- Reset mid-operation: the operation is discarded, out_valid is 0 immediately, and there is no partial result.
- Width rules: shifts use the full WIDTH. Left shifts fill with zeros, and bits shifted past WIDTH-1 are lost.

Decomposition:
- Package seq_extend_alu_pkg holds:
  - the op-class constants OP_MUL=2'b00, OP_SHIFT=2'b01, OP_RSVD=2'b10, OP_ALU=2'b11;
  - the shift-select constants;
  - the FSM state enum {IDLE, MUL, SHIFT, DONE}.
- One sub-module, alu_core, is the WIDTH-parametrised combinational zx/nx/zy/ny/f/no ALU. The multiplier and shifter datapaths stay inline, sharing one accumulator register and one counter.

Test Plan:
- Reset: rst_n low mid-cycle (asynchronous) -> out_valid=0, out=0, zr=0, ng=0, in_ready=1 without waiting for a clock edge.
- ALU add: instruction=0x182, x=3, y=4 -> out=7, zr=0, ng=0, out_valid one cycle after accept. Reserved: instruction=0x100 -> out=0, zr=1.
- Multiply (WIDTH=16): instruction=0x000, x=0xFFFD (-3), y=7 -> out=0xFFEB (-21), ng=1, out_valid exactly 17 cycles after accept. Also x=0x0100, y=0x0100 -> out=0, zr=1 (wrap).
- Shift: instruction=0x094, x=0x8000 -> out=0xF800, ng=1, latency 5. Then instruction=0x0A0, y=0x4000 -> out=0x8000 (n=0 treated as 1), latency 2.
- Backpressure: hold out_ready=0 for 10 cycles after a result while pulsing in_valid -> out, zr and ng stable; in_ready=0; pulses ignored. Release out_ready -> IDLE next cycle, then the next accept proceeds.
- Reset mid-multiply: assert rst_n low 5 cycles after accepting a multiply -> out_valid never rises for it. After release, a fresh ALU op x=5, y=0, instruction=0x182 gives out=5.

Source files
------------

// File: rtl/seq_extend_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_extend_alu_pkg
//  Brief    : Shared op-class / shift-select encodings and FSM states.
//  Revision : 1.0
// ============================================================================
package seq_extend_alu_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_SHIFT = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b10;
    localparam logic [1:0] OP_ALU   = 2'b11;

    localparam logic [1:0] SH_Y_RIGHT = 2'b00;
    localparam logic [1:0] SH_X_RIGHT = 2'b01;
    localparam logic [1:0] SH_Y_LEFT  = 2'b10;
    localparam logic [1:0] SH_X_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_extend_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Brief    : Combinational zx/nx/zy/ny/f/no ALU, WIDTH bits.
//  Revision : 1.0
// ============================================================================
module alu_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_zx,
    input  logic             i_nx,
    input  logic             i_zy,
    input  logic             i_ny,
    input  logic             i_f,
    input  logic             i_no,
    output logic [WIDTH-1:0] o_out
);

    logic [WIDTH-1:0] w_x0, w_x1, w_y0, w_y1, w_f;

    assign w_x0  = i_zx ? '0 : i_x;
    assign w_x1  = i_nx ? ~w_x0 : w_x0;
    assign w_y0  = i_zy ? '0 : i_y;
    assign w_y1  = i_ny ? ~w_y0 : w_y0;
    assign w_f   = i_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign o_out = i_no ? ~w_f : w_f;

endmodule
`default_nettype wire

// File: rtl/seq_extend_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_extend_alu
//  Brief    : Multi-cycle ALU: 1-cycle ALU ops, iterative shift and multiply.
//  Revision : 1.0
// ============================================================================
module seq_extend_alu
    import seq_extend_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [8:0]       instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    localparam int CNT_W = ($clog2(WIDTH) > SHAMT_W) ? $clog2(WIDTH) : SHAMT_W;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_acc, r_mcand, r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_left;
    logic [WIDTH-1:0]   r_out;
    logic               r_zr, r_ng;

    logic               w_accept, w_load_out, w_sh_left;
    logic [1:0]         w_op, w_sh_sel;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_alu_res, w_sh_src, w_acc_shift, w_acc_mul, w_result;
    logic               w_unused_ok;

    assign w_unused_ok = instruction[6];

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out       = r_out;
    assign zr        = r_zr;
    assign ng        = r_ng;

    assign w_accept  = in_valid && in_ready;
    assign w_op      = instruction[8:7];
    assign w_sh_sel  = instruction[5:4];
    assign w_sh_left = (w_sh_sel == SH_Y_LEFT) || (w_sh_sel == SH_X_LEFT);
    assign w_sh_src  = ((w_sh_sel == SH_X_RIGHT) || (w_sh_sel == SH_X_LEFT)) ? x : y;
    // A zero shift amount would mean "no work"; the encoding defines it as 1.
    assign w_shamt   = (instruction[SHAMT_W-1:0] == '0) ? SHAMT_W'(1)
                                                        : instruction[SHAMT_W-1:0];

    assign w_acc_shift = r_left ? {r_acc[WIDTH-2:0], 1'b0}
                                : {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
    assign w_acc_mul   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .i_x   (x),
        .i_y   (y),
        .i_zx  (instruction[5]),
        .i_nx  (instruction[4]),
        .i_zy  (instruction[3]),
        .i_ny  (instruction[2]),
        .i_f   (instruction[1]),
        .i_no  (instruction[0]),
        .o_out (w_alu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_result    = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_MUL:   w_state_nxt = MUL;
                        OP_SHIFT: w_state_nxt = SHIFT;
                        OP_ALU: begin
                            w_state_nxt = DONE;
                            w_load_out  = 1'b1;
                            w_result    = w_alu_res;
                        end
                        default: begin
                            w_state_nxt = DONE;
                            w_load_out  = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                if (r_cnt == CNT_W'(WIDTH-1)) begin
                    w_state_nxt = DONE;
                    w_load_out  = 1'b1;
                    w_result    = w_acc_mul;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                    w_load_out  = 1'b1;
                    w_result    = w_acc_shift;
                end
            end
            DONE: begin
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Shared datapath: r_acc is the product accumulator or the shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_left   <= 1'b0;
            r_out    <= '0;
            r_zr     <= 1'b0;
            r_ng     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && (w_op == OP_MUL)) begin
                        r_acc    <= '0;
                        r_mcand  <= x;
                        r_mplier <= y;
                        r_cnt    <= '0;
                    end else if (w_accept && (w_op == OP_SHIFT)) begin
                        r_acc    <= w_sh_src;
                        r_left   <= w_sh_left;
                        r_cnt    <= CNT_W'(w_shamt);
                    end
                end
                MUL: begin
                    r_acc    <= w_acc_mul;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                SHIFT: begin
                    r_acc <= w_acc_shift;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
            if (w_load_out) begin
                r_out <= w_result;
                r_zr  <= (w_result == '0);
                r_ng  <= w_result[WIDTH-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_extend_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_extend_alu
//  Brief    : Self-checking bench: vector table, corner sequences, random ops.
//  Revision : 1.0
// ============================================================================
module tb_seq_extend_alu;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, zr, ng;
    logic [15:0] x, y, out;
    logic [8:0]  instruction;

    int n_tests = 0;
    int n_fail  = 0;

    seq_extend_alu #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .y           (y),
        .instruction (instruction),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .zr          (zr),
        .ng          (ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] vx;
        logic [15:0] vy;
        logic [8:0]  ins;
        logic [15:0] eout;
        int          elat;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model from the operation definitions, not the iterative datapath.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [8:0] ins,
                                  output logic [15:0] res, output int lat);
        logic [15:0] p, q, src;
        logic [31:0] prod;
        int          n;
        case (ins[8:7])
            2'b11: begin
                p = ins[5] ? 16'h0 : a;
                if (ins[4]) p = ~p;
                q = ins[3] ? 16'h0 : b;
                if (ins[2]) q = ~q;
                res = ins[1] ? (p + q) : (p & q);
                if (ins[0]) res = ~res;
                lat = 1;
            end
            2'b10: begin
                res = 16'h0;
                lat = 1;
            end
            2'b01: begin
                n   = (ins[3:0] == 4'd0) ? 1 : int'(ins[3:0]);
                src = ins[4] ? a : b;
                if (ins[5]) res = src << n;
                else        res = 16'($signed(src) >>> n);
                lat = n + 1;
            end
            default: begin
                prod = a * b;
                res  = prod[15:0];
                lat  = 17;
            end
        endcase
    endfunction

    task automatic do_op(input logic [15:0] ix, input logic [15:0] iy, input logic [8:0] ins,
                         input logic [15:0] eo, input int elat, input int hold,
                         input string nm);
        int lat;
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        x = ix; y = iy; instruction = ins; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(elat));
        chk({nm, " out"}, 32'(out), 32'(eo));
        chk({nm, " zr"}, 32'(zr), 32'(eo == 16'h0));
        chk({nm, " ng"}, 32'(ng), 32'(eo[15]));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " valid drop"}, 32'(out_valid), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] r_x, r_y, r_exp;
        logic [8:0]  r_ins;
        int          r_lat, wait_cnt;
        bit          seen;

        vecs.push_back('{16'd3,    16'd4,    9'h182, 16'd7,    1,  "alu add"});
        vecs.push_back('{16'd3,    16'd4,    9'h1C2, 16'd7,    1,  "alu add bit6"});
        vecs.push_back('{16'd5,    16'd9,    9'h193, 16'hFFFC, 1,  "alu x-y"});
        vecs.push_back('{16'd5,    16'd9,    9'h1BA, 16'hFFFF, 1,  "alu minus1"});
        vecs.push_back('{16'h1234, 16'h5678, 9'h100, 16'h0000, 1,  "reserved"});
        vecs.push_back('{16'hFFFD, 16'd7,    9'h000, 16'hFFEB, 17, "mul neg"});
        vecs.push_back('{16'h0100, 16'h0100, 9'h000, 16'h0000, 17, "mul wrap"});
        vecs.push_back('{16'h8000, 16'h0000, 9'h094, 16'hF800, 5,  "sra x 4"});
        vecs.push_back('{16'h0000, 16'h4000, 9'h0A0, 16'h8000, 2,  "sla y n0"});
        vecs.push_back('{16'h0000, 16'h7FFF, 9'h08F, 16'h0000, 16, "sra y 15"});
        vecs.push_back('{16'h0003, 16'h0000, 9'h0BF, 16'h8000, 16, "sla x 15"});

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; instruction = '0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out", 32'(out), 32'd0);
        chk("rst zr", 32'(zr), 32'd0);
        chk("rst ng", 32'(ng), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i])
            do_op(vecs[i].vx, vecs[i].vy, vecs[i].ins, vecs[i].eout, vecs[i].elat, 0, vecs[i].name);

        // Backpressure with ignored in_valid pulses
        x = 16'hFFFD; y = 16'd7; instruction = 9'h000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("bp result seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            x = 16'd1; y = 16'd1; instruction = 9'h182; in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            chk("bp out", 32'(out), 32'hFFEB);
            chk("bp zr", 32'(zr), 32'd0);
            chk("bp ng", 32'(ng), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release valid", 32'(out_valid), 32'd0);
        chk("bp release ready", 32'(in_ready), 32'd1);
        chk("bp hold out", 32'(out), 32'hFFEB);
        do_op(16'd3, 16'd4, 9'h182, 16'd7, 1, 0, "bp next op");

        // Asynchronous reset while a result is pending
        x = 16'd3; y = 16'd4; instruction = 9'h182; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pend valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2 out_valid", 32'(out_valid), 32'd0);
        chk("rst2 out", 32'(out), 32'd0);
        chk("rst2 in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset 5 cycles into a multiply
        x = 16'd9; y = 16'd9; instruction = 9'h000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mulrst out_valid", 32'(out_valid), 32'd0);
        chk("mulrst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mulrst no result", 32'(seen), 32'd0);
        do_op(16'd5, 16'd0, 9'h182, 16'd5, 1, 0, "after mulrst");

        // Random operations with random consumer backpressure
        for (int i = 0; i < 150; i++) begin
            r_x   = 16'($urandom);
            r_y   = 16'($urandom);
            r_ins = 9'($urandom);
            model(r_x, r_y, r_ins, r_exp, r_lat);
            do_op(r_x, r_y, r_ins, r_exp, r_lat, int'($urandom_range(0, 3)), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
